// File: rtl/arb_pkg.sv
// Shared encodings for the memory bus arbiter: FSM state constants and bus mux selects.
package arb_pkg;

    typedef logic [1:0] arb_state_t;
    typedef logic [1:0] mem_sel_t;

    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_GNT_I   = 2'd1;
    localparam arb_state_t ST_GNT_D   = 2'd2;
    localparam arb_state_t ST_GNT_DMA = 2'd3;

    localparam mem_sel_t SEL_NONE = 2'd0;
    localparam mem_sel_t SEL_I    = 2'd1;
    localparam mem_sel_t SEL_D    = 2'd2;
    localparam mem_sel_t SEL_DMA  = 2'd3;

    // Mux select follows the owner of the bus; kept explicit so state codes may change.
    function automatic mem_sel_t sel_from_state(input arb_state_t st);
        case (st)
            ST_GNT_I:   return SEL_I;
            ST_GNT_D:   return SEL_D;
            ST_GNT_DMA: return SEL_DMA;
            default:    return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Block-transfer latency counter: loads MEM_LAT-1, counts down to zero and holds there.
module lat_counter #(
    parameter int MEM_LAT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CW'(MEM_LAT - 1);
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter for I-cache, D-cache and DMA; fixed priority D > I > DMA.
// Define ARB_STARVE_GUARD_EN to build the DMA starvation guard.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int MEM_LAT  = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       br,
    output logic       i_gnt,
    output logic       d_gnt,
    output logic       bg,
    output logic       i_ready,
    output logic       d_ready,
    output logic [1:0] mem_sel
);

    arb_state_t state_reg;
    arb_state_t state_next;
    logic       lat_load;
    logic       lat_dec;
    logic       lat_zero;
    logic       dma_win;

    lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (lat_load),
        .dec     (lat_dec),
        .zero    (lat_zero)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_WAIT + 1);

    logic [SW-1:0] starve_reg;

    // Counts cycles DMA has been kept off the bus; the grant itself clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_reg <= '0;
        end else if (bg) begin
            starve_reg <= '0;
        end else if (br && (starve_reg != SW'(MAX_WAIT))) begin
            starve_reg <= starve_reg + SW'(1);
        end
    end

    assign dma_win = br && (starve_reg == SW'(MAX_WAIT));
`else
    assign dma_win = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        lat_load   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (dma_win) begin
                    state_next = ST_GNT_DMA;
                end else if (d_req) begin
                    state_next = ST_GNT_D;
                    lat_load   = 1'b1;
                end else if (i_req) begin
                    state_next = ST_GNT_I;
                    lat_load   = 1'b1;
                end else if (br) begin
                    state_next = ST_GNT_DMA;
                end
            end
            // CPU transfers run to completion regardless of the request line.
            ST_GNT_I, ST_GNT_D: begin
                if (lat_zero) begin
                    state_next = ST_IDLE;
                end
            end
            ST_GNT_DMA: begin
                if (!br) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign lat_dec = (state_reg == ST_GNT_I) || (state_reg == ST_GNT_D);

    assign i_gnt   = (state_reg == ST_GNT_I);
    assign d_gnt   = (state_reg == ST_GNT_D);
    assign bg      = (state_reg == ST_GNT_DMA);
    assign i_ready = i_gnt && lat_zero;
    assign d_ready = d_gnt && lat_zero;
    assign mem_sel = sel_from_state(state_reg);

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL provide parameter MEM_LAT, default 4, memory block-transfer latency in cycles (legal range >= 1).
REQ-002 SHALL provide parameter MAX_WAIT, default 8, DMA starvation threshold in cycles (legal range >= 1).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  1  I-cache miss fill request; held high until i_ready.
REQ-006 d_req  input  1  D-cache miss fill/writeback request; held high until d_ready.
REQ-007 br  input  1  DMA bus request; held high for the entire DMA transfer.
REQ-008 i_gnt  output  1  memory bus granted to I-cache.
REQ-009 d_gnt  output  1  memory bus granted to D-cache.
REQ-010 bg  output  1  memory bus granted to DMA controller.
REQ-011 i_ready  output  1  one-cycle pulse: I-cache block transfer complete.
REQ-012 d_ready  output  1  one-cycle pulse: D-cache block transfer complete.
REQ-013 mem_sel  output  2  bus mux select: 0 none, 1 I-cache, 2 D-cache, 3 DMA.

Function
REQ-014 SHALL implement states IDLE, GNT_I, GNT_D and GNT_DMA; i_gnt, d_gnt, bg and mem_sel are decoded from the registered state only.
REQ-015 SHALL arbitrate only in IDLE; priority is D > I > DMA, except as modified by REQ-022.
REQ-016 In IDLE, the winning request at cycle t SHALL move the state to its GNT state at t+1; with no request, the state SHALL stay IDLE.
REQ-017 On entering GNT_I/GNT_D, the latency counter SHALL load MEM_LAT-1 and decrement once per cycle.
REQ-018 In GNT_I/GNT_D, the matching ready pulse SHALL assert in the cycle the counter equals 0, and the state SHALL return to IDLE the next cycle.
REQ-019 Resulting timing: gnt high for exactly MEM_LAT cycles (t+1..t+MEM_LAT), ready at t+MEM_LAT; MEM_LAT=1 gives gnt and ready together in cycle t+1.
REQ-020 Deassertion of i_req/d_req during a grant SHALL be ignored; the transfer completes and ready still pulses.
REQ-021 GNT_DMA SHALL hold bg while br is high, with no preemption; when br is low, the state SHALL go to IDLE the next cycle, and bg SHALL drop at that point.
REQ-022 The starvation counter SHALL increment each cycle with br=1 and bg=0, saturate at MAX_WAIT and clear when bg is granted; when it equals MAX_WAIT in IDLE, DMA SHALL win over D and I.
REQ-023 A CPU grant in progress is never preempted by DMA; starvation only affects the next IDLE decision.
REQ-024 Each grant SHALL pass through IDLE for at least one cycle, so back-to-back grants are separated by one idle cycle.
REQ-025 At most one of i_gnt, d_gnt, bg SHALL be high in any cycle, and i_ready and d_ready SHALL never assert together.

Reset
REQ-026 While reset_n=0: state IDLE, all outputs 0, mem_sel=0, latency and starvation counters 0.
REQ-027 Reset mid-transfer SHALL abort it immediately without a ready pulse; after release, arbitration restarts from IDLE on the first rising edge.

Configuration
REQ-028 Macro ARB_STARVE_GUARD_EN defined: REQ-022 is active.
REQ-029 ARB_STARVE_GUARD_EN undefined: the starvation counter is not built, and fixed priority D > I > DMA always applies.

Structure
REQ-030 Shared package arb_pkg SHALL hold the state encoding constants and the mem_sel encodings (SEL_NONE=0, SEL_I=1, SEL_D=2, SEL_DMA=3).
REQ-031 The latency counter SHALL be one sub-module, lat_counter (load, decrement, zero flag); the FSM and starvation logic stay in mem_bus_arbiter.

Verification
REQ-032 MEM_LAT=4: i_req high at cycle 10 -> i_gnt high cycles 11-14, i_ready pulse cycle 14, IDLE cycle 15, mem_sel=1 during 11-14.
REQ-033 i_req and d_req both high at cycle 5 -> d_gnt cycles 6-9, d_ready cycle 9, IDLE 10, i_gnt cycles 11-14, i_ready 14.
REQ-034 br held with d_req/i_req alternating continuously, MAX_WAIT=8, guard enabled -> bg within 8 cycles plus one in-flight transfer; guard disabled -> bg never asserts while CPU requests persist.
REQ-035 bg granted, br dropped at cycle 20 -> bg low at cycle 21, state IDLE; d_req pending -> d_gnt at cycle 22.
REQ-036 reset_n pulsed low during GNT_D (counter=2) -> d_gnt=0 immediately, no d_ready pulse, d_req still high -> d_gnt reasserts 1 cycle after reset release.
REQ-037 MEM_LAT=1: d_req at cycle 3 -> d_gnt and d_ready both high in cycle 4 only.
